// File: rtl/ssm_pkg.sv
// Types and widths shared by the SSM delta/dA/dBx stages so that the n_idx widths agree.
// The replay FSM state type lives here too, so the stages that follow can decode it.
package ssm_pkg;

  localparam int DW      = 16;
  localparam int N_STATE = 128;

  typedef logic [DW-1:0] fp16_t;

  typedef enum logic {
    IDLE   = 1'b0,
    REPLAY = 1'b1
  } rep_state_t;

  // A single-state dimension still needs a one-bit index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_IDX_W = idx_w(N_STATE);

endpackage

// File: rtl/delta_fifo.sv
// Synchronous DEPTH-entry FIFO holding deltas waiting to be replayed.
// Latency: a push is visible at dout on the next cycle; dout shows mem[rd_ptr] even when empty.
// Backpressure: push on full is taken only when a pop happens in the same cycle.
module delta_fifo
  import ssm_pkg::*;
#(
  parameter int  DW    = ssm_pkg::DW,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/delta_bcast.sv
// Buffers one delta per head and replays it N times tagged with n_idx; DELTA_BCAST_STALL_CNT_EN adds stall_cnt_o.
// Latency: one cycle from valid_i into an empty FIFO to valid_o; no combinational input-to-output path.
// Backpressure: ready_i stalls the replay; upstream has no ready, so a push into a full FIFO is dropped and flagged.
module delta_bcast
  import ssm_pkg::*;
#(
  parameter int  DW    = ssm_pkg::DW,
  parameter int  N     = ssm_pkg::N_STATE,
  parameter int  DEPTH = 4,
  localparam int IW    = idx_w(N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          valid_i,
  input  logic [DW-1:0] delta_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] delta_o,
  output logic [IW-1:0] n_idx_o,
  output logic          last_o,
  output logic          overflow_o
`ifdef DELTA_BCAST_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt_o
`endif
);

  localparam int            CW     = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] N_LAST = IW'(N - 1);

  rep_state_t    state;
  logic [IW-1:0] n;
  logic          xfer;
  logic          push;
  logic          pop;
  logic          drop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [DW-1:0] head;

  assign valid_o   = (state == REPLAY);
  assign n_idx_o   = n;
  assign last_o    = valid_o & (n == N_LAST);
  assign delta_o   = empty ? '0 : head;

  assign xfer      = valid_o & ready_i;
  assign pop       = xfer & (n == N_LAST);
  assign push      = valid_i & (~full | pop);
  assign drop      = valid_i & full & ~pop;
  assign count_nxt = count + CW'(push) - CW'(pop);

  delta_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .din   (delta_i),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // State tracks the FIFO occupancy one edge ahead so valid_o comes straight from a flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      n          <= '0;
      overflow_o <= 1'b0;
    end else begin
      state <= (count_nxt != '0) ? REPLAY : IDLE;
      if (pop) begin
        n <= '0;
      end else if (xfer) begin
        n <= n + 1'b1;
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

`ifdef DELTA_BCAST_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_o <= '0;
    end else if (valid_o && !ready_i && !(&stall_cnt_o)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
